// File: rtl/ttseq_pkg.sv
// Shared definitions for the truth-table sequencer: FSM states, vector count
// and the index width used to walk the eight input vectors.
package ttseq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int NUM_VECTORS = 8;
   localparam int INDEX_W     = 3;
   localparam int FAIL_W      = 4;

   localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_VECTORS - 1);
   localparam logic [FAIL_W-1:0]  FAIL_MAX   = FAIL_W'(NUM_VECTORS);

endpackage

// File: rtl/ttseq_dwell_timer.sv
// Dwell timer: counts 0..HOLD_CYCLES-1 while enabled and wraps to 0.
// 'last' flags the final cycle of the dwell, which is the sample cycle.
module ttseq_dwell_timer #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic last
);

   localparam logic [7:0] TERMINAL = 8'(HOLD_CYCLES - 1);

   logic [7:0] count;

   assign last = (count == TERMINAL);

   // Dwell counter: cleared outside a sweep, wraps after the sample cycle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // sees the pre-edge value of every other register.
      if (reset || clear) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= last ? 8'd0 : count + 8'd1;
      end
   end

endmodule

// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps {a,b,c} through 000..111, holding each vector
// HOLD_CYCLES cycles, samples y on the last cycle of each dwell and compares
// it with the golden table. Optional macro TTSEQ_STOP_ON_FAIL_EN ends the
// sweep right after the first mismatching sample.
module truth_table_sequencer
   import ttseq_pkg::*;
#(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] expected,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_count,
   output logic [7:0] captured
);

   state_t             state;
   state_t             state_next;
   logic [INDEX_W-1:0] index;
   logic               dwell_last;
   logic               start_accept;
   logic               sample;
   logic               mismatch;
   logic               stop_now;

   ttseq_dwell_timer #(
      .HOLD_CYCLES(HOLD_CYCLES)
   ) u_dwell (
      .clk   (clk),
      .reset (reset),
      .clear (state != APPLY),
      .enable(state == APPLY),
      .last  (dwell_last)
   );

   // A start pulse is only honoured when no sweep is running.
   assign start_accept = start && (state != APPLY);
   assign sample       = (state == APPLY) && dwell_last;
   assign mismatch     = (y != expected[index]);

`ifdef TTSEQ_STOP_ON_FAIL_EN
   assign stop_now = sample && (mismatch || (index == LAST_INDEX));
`else
   assign stop_now = sample && (index == LAST_INDEX);
`endif

   // State register; reset overrides any start seen in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: defaulting state_next before the case keeps every path assigned,
      // so no latch is inferred.
      state_next = state;
      case (state)
         IDLE,
         DONE:    if (start) state_next = APPLY;
         APPLY:   if (stop_now) state_next = DONE;
         default: state_next = IDLE;
      endcase
   end

   // Sweep datapath: vector index, captured responses and saturating miss count.
   always_ff @(posedge clk) begin
      if (reset || start_accept) begin
         index      <= '0;
         captured   <= 8'h00;
         fail_count <= 4'd0;
      end else if (sample) begin
         captured[index] <= y;
         if (mismatch && (fail_count != FAIL_MAX)) begin
            fail_count <= fail_count + 4'd1;
         end
         if (index != LAST_INDEX) begin
            index <= index + 1'b1;
         end
      end
   end

   // Outputs depend only on registered state, never on y directly.
   assign {a, b, c} = (state == APPLY) ? index : 3'b000;
   assign busy      = (state == APPLY);
   assign done      = (state == DONE);
   assign pass      = done && (fail_count == 4'd0);

endmodule

// File: doc/truth_table_sequencer.md
TRUTH_TABLE_SEQUENCER -- requirements
Module: truth_table_sequencer

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: clock cycles each input vector is held (range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: a one-cycle pulse that starts a sweep.
REQ-005 SHALL have port expected, input, 8: the golden truth table; bit i is the expected y for vector i.
REQ-006 SHALL have port y, input, 1: the combinational response of the device under test.
REQ-007 SHALL have ports a, b, c, outputs, 1 each: the vector driven to the device under test.
REQ-008 SHALL have port busy, output, 1: a sweep is in progress.
REQ-009 SHALL have port done, output, 1: a sweep has completed; held until the next start or reset.
REQ-010 SHALL have port pass, output, 1: done and zero mismatches.
REQ-011 SHALL have port fail_count, output, 4: the number of mismatching vectors (0..8).
REQ-012 SHALL have port captured, output, 8: the sampled y per vector; bit i is vector i.

Function
REQ-013 SHALL implement the states IDLE, APPLY and DONE.
REQ-014 SHALL, in IDLE or DONE, on start: clear captured and fail_count, set vector index to 0, clear the dwell count, and enter APPLY.
REQ-015 SHALL, in APPLY, drive {a,b,c} = index[2:0]; in IDLE and DONE {a,b,c} SHALL be 3'b000.
REQ-016 SHALL hold each vector for exactly HOLD_CYCLES cycles, with the dwell counter running 0..HOLD_CYCLES-1.
REQ-017 SHALL, on the cycle where dwell equals HOLD_CYCLES-1: register captured[index] <= y and, if y != expected[index], increment fail_count.
REQ-018 SHALL, after sampling, advance to index+1 with dwell 0 if index < 7; if index == 7, enter DONE.
REQ-019 SHALL give a sweep length of exactly 8*HOLD_CYCLES cycles in APPLY; done SHALL rise on the cycle after the final sample.
REQ-020 SHALL assert busy if and only if in APPLY; done SHALL be asserted if and only if in DONE.
REQ-021 SHALL ignore start while busy, with no restart and no effect on the counters.
REQ-022 SHALL restart from DONE on start, beginning APPLY the next cycle with cleared results.
REQ-023 SHALL sample the expected input only at the sample cycle; changes to it mid-sweep affect only the remaining vectors.
REQ-024 SHALL keep fail_count from wrapping; its maximum is 8.
REQ-025 SHALL compute pass = done & (fail_count == 0).

Reset
REQ-026 SHALL, on reset, enter IDLE with index=0, dwell=0, captured=8'h00, fail_count=0, and busy, done, pass and {a,b,c} all 0.
REQ-027 SHALL let reset asserted mid-sweep abort the sweep the next cycle, with no done pulse and results cleared.
REQ-028 SHALL give reset priority over start when both are asserted in the same cycle.

Configuration
REQ-029 SHALL, when TTSEQ_STOP_ON_FAIL_EN is defined, enter DONE on the cycle after the first mismatch sample, leaving captured bits of the unvisited vectors at 0 and fail_count=1.
REQ-030 SHALL, when TTSEQ_STOP_ON_FAIL_EN is undefined, always sweep all 8 vectors.

Structure
REQ-031 SHALL take the state enum (IDLE/APPLY/DONE), NUM_VECTORS=8 and the index width (3) from the shared package ttseq_pkg.
REQ-032 SHALL implement the dwell timer as sub-module ttseq_dwell_timer (parameter HOLD_CYCLES; inputs clk, reset, clear, enable; output last).
REQ-033 SHALL contain no combinational path from y to any output; all results SHALL be registered.

Verification
REQ-034 SHALL be covered by: DUT y = ~b&~c | a&~b, expected=8'h31, HOLD_CYCLES=1, start -> busy for 8 cycles, done, captured=8'h31, fail_count=0, pass=1.
REQ-035 SHALL be covered by: same DUT, expected=8'h30 -> captured=8'h31, fail_count=1, pass=0; with TTSEQ_STOP_ON_FAIL_EN defined -> DONE after vector 0, captured=8'h01.
REQ-036 SHALL be covered by: HOLD_CYCLES=10 -> each {a,b,c} value held 10 cycles in order 000..111, and done asserted 80 cycles after APPLY entry.
REQ-037 SHALL be covered by: y tied 0, expected=8'hFF -> fail_count=8 with no wrap, captured=8'h00.
REQ-038 SHALL be covered by: start pulsed at sweep cycle 3 -> ignored and sweep length unchanged; reset at cycle 5 -> IDLE, all outputs 0, done never asserted.
REQ-039 SHALL be covered by: start in DONE -> new sweep begins next cycle, fail_count and captured cleared first, and results reproduce the first run.
